// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl
// Steps a 4-bit LED pattern at a programmable rate. A prescaler counts
// clock cycles up to a latched limit (DELAY_1S >> speed). On the wrap edge
// the pattern advances one step and step_tick pulses for one cycle.
//
// Ports
//   sclk       system clock, rising edge
//   s_rst      asynchronous active-high reset
//   mode_req   one-cycle strobe: load mode_sel and restart its pattern
//   mode_sel   requested mode (0 SHL, 1 SHR, 2 PINGPONG, 3 BLINK)
//   speed      rate select, step limit = DELAY_1S >> speed
//   pause      level, freezes prescaler, pattern and direction
//   led        registered LED pattern
//   mode       registered active mode
//   step_tick  registered pulse, high in the cycle led takes a new step
//
// state (mode) | meaning
// -------------+------------------------------------------------
// M_SHL        | one-hot rotating left  0001->0010->0100->1000
// M_SHR        | one-hot rotating right 1000->0100->0010->0001
// M_PING       | one-hot bouncing between 0001 and 1000
// M_BLINK      | all LEDs toggling 1111 <-> 0000

module led_pattern_ctrl #(
    parameter int DELAY_1S = 49_999_999
) (
    input  logic       sclk,
    input  logic       s_rst,
    input  logic       mode_req,
    input  logic [1:0] mode_sel,
    input  logic [1:0] speed,
    input  logic       pause,
    output logic [3:0] led,
    output logic [1:0] mode,
    output logic       step_tick
);

    localparam int PW = (DELAY_1S > 0) ? $clog2(DELAY_1S + 1) : 1;
    localparam logic [PW-1:0] DELAY_V = PW'(DELAY_1S);

    typedef enum logic [1:0] {
        M_SHL   = 2'd0,
        M_SHR   = 2'd1,
        M_PING  = 2'd2,
        M_BLINK = 2'd3
    } mode_t;

    mode_t         mode_q;
    logic [PW-1:0] presc;
    logic [PW-1:0] limit;
    logic          dir_up;

    logic [PW-1:0] lim_next;
    logic [3:0]    led_init;
    logic [3:0]    led_step;
    logic          dir_step;

    assign mode     = mode_q;
    assign lim_next = DELAY_V >> speed;

    always_comb begin
        led_init = 4'b0001;
        case (mode_t'(mode_sel))
            M_SHL:   led_init = 4'b0001;
            M_SHR:   led_init = 4'b1000;
            M_PING:  led_init = 4'b0001;
            M_BLINK: led_init = 4'b1111;
            default: led_init = 4'b0001;
        endcase
    end

    // Ping-pong flips direction on the step that lands on an end position,
    // so the following step already moves away from that end.
    always_comb begin
        led_step = led;
        dir_step = dir_up;
        case (mode_q)
            M_SHL:   led_step = {led[2:0], led[3]};
            M_SHR:   led_step = {led[0], led[3:1]};
            M_PING: begin
                if (dir_up) begin
                    led_step = {led[2:0], 1'b0};
                    if (led[2]) dir_step = 1'b0;
                end else begin
                    led_step = {1'b0, led[3:1]};
                    if (led[1]) dir_step = 1'b1;
                end
            end
            M_BLINK: led_step = ~led;
            default: led_step = led;
        endcase
    end

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            mode_q    <= M_SHL;
            led       <= 4'b0001;
            step_tick <= 1'b0;
            presc     <= '0;
            limit     <= DELAY_V;
            dir_up    <= 1'b1;
        end else begin
            step_tick <= 1'b0;
            if (mode_req) begin
                // A mode request wins over a coinciding step.
                mode_q <= mode_t'(mode_sel);
                led    <= led_init;
                dir_up <= 1'b1;
                presc  <= '0;
                limit  <= lim_next;
            end else if (!pause) begin
                if (presc == limit) begin
                    presc     <= '0;
                    limit     <= lim_next;
                    led       <= led_step;
                    dir_up    <= dir_step;
                    step_tick <= 1'b1;
                end else begin
                    presc <= presc + PW'(1);
                end
            end
        end
    end

endmodule

// File: doc/led_pattern_ctrl.md
LED_PATTERN_CTRL -- requirements
Module: led_pattern_ctrl

Interface
REQ-001 The block SHALL have parameter DELAY_1S, default 49_999_999, meaning step-period limit in clock cycles minus one at speed 0.
REQ-002 The block SHALL have port sclk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port s_rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port mode_req, input, 1 bit: single-cycle mode-change strobe.
REQ-005 The block SHALL have port mode_sel, input, 2 bits: requested mode, sampled when mode_req=1 (0 SHL, 1 SHR, 2 PINGPONG, 3 BLINK).
REQ-006 The block SHALL have port speed, input, 2 bits: rate select, where step limit = DELAY_1S >> speed.
REQ-007 The block SHALL have port pause, input, 1 bit: level; when high, pattern advance is frozen.
REQ-008 The block SHALL have port led, output, 4 bits: registered LED pattern.
REQ-009 The block SHALL have port mode, output, 2 bits: registered active mode.
REQ-010 The block SHALL have port step_tick, output, 1 bit: registered one-cycle pulse, high in the cycle led takes a new step value.

Function
REQ-011 The prescaler SHALL be an internal counter of width ceil(log2(DELAY_1S+1)), incrementing by 1 per cycle while pause=0.
REQ-012 When the prescaler equals the latched limit and pause=0, the next edge SHALL clear the prescaler, advance led one step and set step_tick=1; step_tick SHALL be 0 in all other cycles.
REQ-013 The limit SHALL be re-latched from DELAY_1S >> speed only at prescaler wrap, on mode_req and at reset; speed changes mid-period SHALL NOT shorten the current period.
REQ-014 SHL sequence SHALL be 0001->0010->0100->1000->0001 (wrap).
REQ-015 SHR sequence SHALL be 1000->0100->0010->0001->1000 (wrap).
REQ-016 PINGPONG SHALL use a direction flag: up moves left, down moves right; direction SHALL flip on reaching 1000 (to down) or 0001 (to up), giving 0001,0010,0100,1000,0100,0010,0001,0010,...
REQ-017 BLINK SHALL toggle between 1111 and 0000.
REQ-018 On mode_req=1, the next edge SHALL set mode=mode_sel, load the mode's initial pattern (SHL 0001, SHR 1000, PINGPONG 0001 with direction up, BLINK 1111), clear the prescaler, re-latch the limit and force step_tick=0.
REQ-019 mode_req with mode_sel equal to the current mode SHALL still restart the pattern per REQ-018.
REQ-020 mode_req SHALL take priority over a step coinciding in the same cycle; no step SHALL occur that cycle.
REQ-021 mode_req while pause=1 SHALL be honoured per REQ-018; the pattern SHALL then stay at its initial value until pause falls.
REQ-022 While pause=1, the prescaler, led and direction SHALL hold, and step_tick SHALL be 0; counting SHALL resume from the held prescaler value.
REQ-023 led SHALL never take a value outside the active mode's sequence (a one-hot pattern in SHL, SHR and PINGPONG).
REQ-024 The limit arithmetic SHALL be a logical right shift; DELAY_1S >> speed equal to 0 SHALL give a step every cycle.

Reset
REQ-025 While s_rst=1, asynchronously: led=0001, mode=0 (SHL), step_tick=0, prescaler=0, direction up, limit=DELAY_1S.
REQ-026 Reset asserted mid-period or mid-sequence SHALL discard all progress; after release, the first step SHALL occur DELAY_1S+1 cycles later.

Verification (DELAY_1S=49, 10 ns clock)
REQ-027 The bench SHALL cover: release s_rst, speed=0, pause=0 -> led=0010 with step_tick=1 on the 50th rising edge after release; 0100 at edge 100; 0001 again at edge 200.
REQ-028 The bench SHALL cover: mode_req with mode_sel=2 -> next cycle mode=2, led=0001; then led steps 0010,0100,1000,0100,0010,0001 every 50 cycles.
REQ-029 The bench SHALL cover: speed=1 written mid-period -> current period still 50 cycles, subsequent periods 25 cycles; speed=3 -> 7-cycle periods (limit 6).
REQ-030 The bench SHALL cover: pause=1 for 30 cycles at prescaler=20 -> led frozen and no step_tick; next step 30 cycles after pause falls.
REQ-031 The bench SHALL cover: mode_req (mode_sel=3) in the same cycle as a step -> led=1111, no step_tick, next toggle to 0000 50 cycles later.
REQ-032 The bench SHALL cover: s_rst pulsed mid-PINGPONG with led=0100 and direction down -> immediately led=0001, mode=0; next step to 0010 after 50 cycles.
